// File: rtl/alu_result_checker.sv
// Consumer-side checker for a 32-bit ALU: recomputes each sampled result, counts pass/fail per session.
// Optional MISR signature over compared results when MISR_EN is defined; otherwise signature is 0.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] signature
);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [2:0]       op;
    logic [CNT_W-1:0] idx;
  } smp_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] num_r, idx;
  logic [STAGES:0]  vld_pipe;
  smp_t             s1;
  logic             fail_q, fire, start_ok, last, match;
  logic [WIDTH-1:0] golden;

  assign in_ready = (state == RUN) && (idx < num_r);
  assign fire     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign last     = fire && (idx == num_r - CNT_W'(1));
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign mismatch = vld_pipe[1] && fail_q;

  always_comb begin
    golden = '0;
    case (s1.op)
      3'd0: golden = s1.a & s1.b;
      3'd1: golden = s1.a | s1.b;
      3'd2: golden = s1.a + s1.b;
      3'd3: golden = '0;
      3'd4: golden = s1.a & ~s1.b;
      3'd5: golden = s1.a | ~s1.b;
      3'd6: golden = s1.a - s1.b;
      3'd7: golden = {{(WIDTH-1){1'b0}}, ($signed(s1.a) < $signed(s1.b))};
      default: golden = '0;
    endcase
  end
  assign match = (golden == s1.res);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (num_samples == '0) ? DONE : RUN;
      RUN:        if (last) state_nx = DRAIN;
      DRAIN:      if (vld_pipe == '0) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Stage 1 holds the accepted sample; stage 2 only times the mismatch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      fail_q   <= 1'b0;
      idx      <= '0;
      num_r    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], fire};
      fail_q   <= vld_pipe[0] && !match;
      if (fire) begin
        s1  <= '{a: a, b: b, res: result, op: alu_control, idx: idx};
        idx <= idx + CNT_W'(1);
      end
      if (start_ok) begin
        idx   <= '0;
        num_r <= num_samples;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
    end else if (start_ok) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
    end else if (vld_pipe[0]) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (fail_cnt == '0) first_fail_idx <= s1.idx;
      end
    end
  end

`ifdef MISR_EN
  logic [WIDTH-1:0] sig;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sig <= '0;
    else if (start_ok)    sig <= '0;
    else if (vld_pipe[0]) sig <= {sig[WIDTH-2:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ s1.res;
  end
  assign signature = sig;
`else
  assign signature = '0;
`endif
endmodule
